// File: rtl/lab3_logic_pipe.sv
// Two-stage 3-operand logic/arith unit with held result and
// saturating change counter.
module lab3_logic_pipe #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     y,
    output logic                 y_changed,
    output logic [CNT_WIDTH-1:0] change_count
);

    localparam logic [1:0] M_SEL = 2'b00;
    localparam logic [1:0] M_PAR = 2'b01;
    localparam logic [1:0] M_MAJ = 2'b10;
    localparam logic [1:0] M_SUM = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_c;
    logic [1:0]           r_mode;
    logic                 r_vld;

    logic [WIDTH-1:0]     r_y;
    logic                 r_ovld;
    logic                 r_chg;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [WIDTH-1:0]     w_f;
    logic                 w_diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_mode <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_a    <= a;
            r_b    <= b;
            r_c    <= c;
            r_mode <= mode;
            r_vld  <= in_valid;
        end
    end

    always_comb begin
        w_f = '0;
        unique case (r_mode)
            M_SEL: w_f = (r_a & r_b) | (~r_a & r_c);
            M_PAR: w_f = r_a ^ r_b ^ r_c;
            M_MAJ: w_f = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);
            M_SUM: w_f = r_a + r_b + r_c;
            default: w_f = '0;
        endcase
    end

    assign w_diff = (w_f != r_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y    <= '0;
            r_ovld <= 1'b0;
            r_chg  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_ovld <= r_vld;
            r_chg  <= r_vld & w_diff;
            if (r_vld) begin
                r_y <= w_f;
                // Pulse still fires at saturation; only the count stops.
                if (w_diff && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign out_valid    = r_ovld;
    assign y            = r_y;
    assign y_changed    = r_chg;
    assign change_count = r_cnt;

endmodule

// File: tb/tb_lab3_logic_pipe.sv
// Scoreboard bench: directed beats push expected y, monitor pops on out_valid.
module tb_lab3_logic_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic [1:0]   mode = '0;

    logic         ov_m, ov_s;
    logic [W-1:0] y_m, y_s;
    logic         ch_m, ch_s;
    logic [7:0]   cnt_m;
    logic [1:0]   cnt_s;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    lab3_logic_pipe #(.WIDTH(W), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .mode(mode),
        .out_valid(ov_m), .y(y_m), .y_changed(ch_m),
        .change_count(cnt_m)
    );

    lab3_logic_pipe #(.WIDTH(W), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .mode(mode),
        .out_valid(ov_s), .y(y_s), .y_changed(ch_s),
        .change_count(cnt_s)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic beat(input logic [1:0] m, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [W-1:0] ic,
                        input logic [W-1:0] ey);
        @(negedge clk);
        in_valid = 1'b1;
        mode = m;
        a = ia;
        b = ib;
        c = ic;
        if (!reset) q.push_back(ey);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            c = W'($urandom);
            mode = 2'($urandom);
        end
    endtask

    logic [W-1:0] e_held = '0;
    int           e_cnt  = 0;
    int           e_sat  = 0;

    initial begin : monitor
        logic [W-1:0] e;
        logic         chg;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                q.delete();
                e_held = '0;
                e_cnt = 0;
                e_sat = 0;
                chk("rst_ov", {31'd0, ov_m | ov_s}, 0);
                chk("rst_y", {24'd0, y_m, y_s}, 0);
                chk("rst_chg", {31'd0, ch_m | ch_s}, 0);
                chk("rst_cnt", {22'd0, cnt_m, cnt_s}, 0);
            end else if (ov_m || ov_s) begin
                chk("ov_match", {31'd0, ov_s}, {31'd0, ov_m});
                if (q.size() == 0) begin
                    chk("unexpected_ov", 1, 0);
                end else begin
                    e = q.pop_front();
                    chg = (e != e_held);
                    if (chg && e_cnt < 255) e_cnt++;
                    if (chg && e_sat < 3) e_sat++;
                    e_held = e;
                    chk("y", {28'd0, y_m}, {28'd0, e});
                    chk("y_sat", {28'd0, y_s}, {28'd0, e});
                    chk("y_changed", {31'd0, ch_m}, {31'd0, chg});
                    chk("y_changed_sat", {31'd0, ch_s}, {31'd0, chg});
                    chk("count", {24'd0, cnt_m}, e_cnt);
                    chk("count_sat", {30'd0, cnt_s}, e_sat);
                end
            end else begin
                chk("hold_y", {28'd0, y_m}, {28'd0, e_held});
                chk("hold_y_sat", {28'd0, y_s}, {28'd0, e_held});
                chk("idle_chg", {31'd0, ch_m | ch_s}, 0);
                chk("idle_count", {24'd0, cnt_m}, e_cnt);
                chk("idle_count_sat", {30'd0, cnt_s}, e_sat);
            end
        end
    end

    initial begin
        // Reset held two cycles with valid random beats (dropped).
        reset = 1'b1;
        beat(2'($urandom), W'($urandom), W'($urandom), W'($urandom), '0);
        beat(2'($urandom), W'($urandom), W'($urandom), W'($urandom), '0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        idle(2);
        chk("post_rst_empty", q.size(), 0);

        // Select, parity, majority, sum-wrap back to back.
        beat(2'b00, 4'b1010, 4'b0100, 4'b0111, 4'b0101);
        beat(2'b01, 4'b1010, 4'b0100, 4'b0111, 4'b1001);
        beat(2'b10, 4'b1010, 4'b0100, 4'b1100, 4'b1100);
        beat(2'b11, 4'b1011, 4'b0111, 4'b1100, 4'b1110);
        // Repeat: no change.
        beat(2'b11, 4'b1011, 4'b0111, 4'b1100, 4'b1110);
        idle(5);

        // Saturation run on the 2-bit counter instance.
        beat(2'b01, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        beat(2'b01, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        beat(2'b01, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        beat(2'b01, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        beat(2'b01, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
        idle(4);
        chk("sat_drained", q.size(), 0);
        chk("sat_count_end", {30'd0, cnt_s}, 3);

        // Reset one cycle after a beat: beat dropped.
        beat(2'b01, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        beat(2'b11, 4'b0001, 4'b0010, 4'b0011, 4'b0110);
        idle(4);

        chk("final_empty", q.size(), 0);
        chk("final_y", {28'd0, y_m}, 32'h6);
        chk("final_count", {24'd0, cnt_m}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
